// File: rtl/stack_frame_ctrl.sv
// stack_frame_ctrl: command front-end for the SuperStack operand stack.
// Turns PUSH/POP/CALL/RETURN commands into timed stack op sequences and
// keeps a LIFO of saved underflow limits, one per active call frame.
// Optional feature macro: STACK_FRAME_HIWATER_EN enables frame_hiwater
// tracking (max frame_depth since reset); otherwise frame_hiwater is 0.
module stack_frame_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 7,
    parameter int FRAME_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd,
    input  logic [WIDTH-1:0]       cmd_data,
    input  logic [DEPTH:0]         cmd_nargs,
    input  logic                   cmd_nres,
    output logic                   rsp_valid,
    output logic [2:0]             rsp_err,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [2:0]             stk_op,
    output logic [WIDTH-1:0]       stk_data,
    output logic [DEPTH:0]         stk_limit,
    input  logic [DEPTH:0]         stk_index,
    input  logic [WIDTH-1:0]       stk_tos,
    input  logic [2:0]             stk_status,
    output logic [FRAME_DEPTH:0]   frame_depth,
    output logic [FRAME_DEPTH:0]   frame_hiwater
);

    // Command encodings
    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_PUSH   = 3'd1;
    localparam logic [2:0] CMD_POP    = 3'd2;
    localparam logic [2:0] CMD_CALL   = 3'd3;
    localparam logic [2:0] CMD_RETURN = 3'd4;

    // Response codes
    localparam logic [2:0] ERR_OK        = 3'd0;
    localparam logic [2:0] ERR_STACK     = 3'd1;
    localparam logic [2:0] ERR_FRAME_OVF = 3'd2;
    localparam logic [2:0] ERR_FRAME_UNF = 3'd3;
    localparam logic [2:0] ERR_ARGS      = 3'd4;
    localparam logic [2:0] ERR_BAD_CMD   = 3'd5;

    // Stack op / status encodings, mirroring the attached stack's stack.vh
    localparam logic [2:0] OP_NONE            = 3'd0;
    localparam logic [2:0] OP_PUSH            = 3'd1;
    localparam logic [2:0] OP_POP             = 3'd2;
    localparam logic [2:0] OP_UNDERFLOW_PUSH  = 3'd3;
    localparam logic [2:0] OP_UNDERFLOW_RESET = 3'd4;
    localparam logic [2:0] ST_OVERFLOW        = 3'd1;
    localparam logic [2:0] ST_UNDERFLOW       = 3'd2;

    localparam int FD_W   = FRAME_DEPTH + 1;
    localparam int FRAMES = 1 << FRAME_DEPTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RESTORE = 2'd2,
        S_WAIT    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             cmd_q, cmd_d;
    logic [2:0]             err_q, err_d;
    logic [WIDTH-1:0]       cap_q, cap_d;
    logic [2:0]             stk_op_q, stk_op_d;
    logic [WIDTH-1:0]       stk_data_q, stk_data_d;
    logic [DEPTH:0]         stk_limit_q, stk_limit_d;
    logic [FD_W-1:0]        frame_depth_q, frame_depth_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [2:0]             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0]       rsp_data_q, rsp_data_d;

    // Saved caller limits; entry k belongs to the frame opened at depth k
    logic [DEPTH:0]         lifo_q [FRAMES];
    logic                   lifo_we_s;
    logic [FRAME_DEPTH-1:0] wr_idx_s;
    logic [FRAME_DEPTH-1:0] rd_idx_s;

    logic [DEPTH:0]         avail_s;
    logic                   frame_full_s;
    logic [2:0]             accept_err_s;

    assign wr_idx_s     = frame_depth_q[FRAME_DEPTH-1:0];
    assign rd_idx_s     = wr_idx_s - FRAME_DEPTH'(1);
    assign frame_full_s = (frame_depth_q == FD_W'(FRAMES));

    // Operands visible to the current frame; ordered check keeps the subtraction from wrapping
    always_comb begin
        if (stk_index >= stk_limit_q) begin
            avail_s = stk_index - stk_limit_q;
        end else begin
            avail_s = '0;
        end
    end

    // Accept-cycle validation, first failing check wins
    always_comb begin
        accept_err_s = ERR_OK;
        case (cmd)
            CMD_NOP, CMD_PUSH, CMD_POP: begin
                accept_err_s = ERR_OK;
            end
            CMD_CALL: begin
                if (frame_full_s) begin
                    accept_err_s = ERR_FRAME_OVF;
                end else if (cmd_nargs > avail_s) begin
                    accept_err_s = ERR_ARGS;
                end else begin
                    accept_err_s = ERR_OK;
                end
            end
            CMD_RETURN: begin
                if (frame_depth_q == FD_W'(0)) begin
                    accept_err_s = ERR_FRAME_UNF;
                end else if (cmd_nres && (stk_index == stk_limit_q)) begin
                    accept_err_s = ERR_ARGS;
                end else begin
                    accept_err_s = ERR_OK;
                end
            end
            default: begin
                accept_err_s = ERR_BAD_CMD;
            end
        endcase
    end

    // Next-state and next-output logic for the command sequencer
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        err_d         = err_q;
        cap_d         = cap_q;
        stk_op_d      = OP_NONE;
        stk_data_d    = '0;
        stk_limit_d   = stk_limit_q;
        frame_depth_d = frame_depth_q;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = ERR_OK;
        rsp_data_d    = '0;
        lifo_we_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d = cmd;
                    err_d = accept_err_s;
                    cap_d = stk_tos;
                    if (accept_err_s != ERR_OK) begin
                        state_d = S_WAIT;
                    end else begin
                        case (cmd)
                            CMD_PUSH: begin
                                state_d    = S_ISSUE;
                                stk_op_d   = OP_PUSH;
                                stk_data_d = cmd_data;
                            end
                            CMD_POP: begin
                                state_d  = S_ISSUE;
                                stk_op_d = OP_POP;
                            end
                            CMD_CALL: begin
                                // Save caller limit, callee sees args onward
                                lifo_we_s     = 1'b1;
                                frame_depth_d = frame_depth_q + FD_W'(1);
                                stk_limit_d   = stk_index - cmd_nargs;
                                state_d       = S_WAIT;
                            end
                            CMD_RETURN: begin
                                state_d = S_ISSUE;
                                if (cmd_nres) begin
                                    stk_op_d   = OP_UNDERFLOW_PUSH;
                                    stk_data_d = stk_tos;
                                end else begin
                                    stk_op_d   = OP_UNDERFLOW_RESET;
                                end
                            end
                            default: begin
                                state_d = S_WAIT;
                            end
                        endcase
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (cmd_q == CMD_RETURN) begin
                    state_d = S_RESTORE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESTORE: begin
                stk_limit_d   = lifo_q[rd_idx_s];
                frame_depth_d = frame_depth_q - FD_W'(1);
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                if (err_q != ERR_OK) begin
                    rsp_err_d = err_q;
                end else begin
                    case (cmd_q)
                        CMD_PUSH: begin
                            if (stk_status == ST_OVERFLOW) begin
                                rsp_err_d = ERR_STACK;
                            end else begin
                                rsp_err_d = ERR_OK;
                            end
                        end
                        CMD_POP: begin
                            if (stk_status == ST_UNDERFLOW) begin
                                rsp_err_d = ERR_STACK;
                            end else begin
                                rsp_data_d = cap_q;
                            end
                        end
                        CMD_RETURN: begin
                            if ((stk_status == ST_OVERFLOW) || (stk_status == ST_UNDERFLOW)) begin
                                rsp_err_d = ERR_STACK;
                            end else begin
                                rsp_err_d = ERR_OK;
                            end
                        end
                        default: begin
                            rsp_err_d = ERR_OK;
                        end
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cmd_q         <= CMD_NOP;
            err_q         <= ERR_OK;
            cap_q         <= '0;
            stk_op_q      <= OP_NONE;
            stk_data_q    <= '0;
            stk_limit_q   <= '0;
            frame_depth_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= ERR_OK;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            err_q         <= err_d;
            cap_q         <= cap_d;
            stk_op_q      <= stk_op_d;
            stk_data_q    <= stk_data_d;
            stk_limit_q   <= stk_limit_d;
            frame_depth_q <= frame_depth_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    // Frame LIFO storage; contents above frame_depth are don't-care, so no reset
    always_ff @(posedge clk) begin
        if (lifo_we_s) begin
            lifo_q[wr_idx_s] <= stk_limit_q;
        end
    end

`ifdef STACK_FRAME_HIWATER_EN
    logic [FD_W-1:0] hiwater_q, hiwater_d;

    // Track deepest frame nesting seen; follows frame_depth by one cycle
    always_comb begin
        if (frame_depth_q > hiwater_q) begin
            hiwater_d = frame_depth_q;
        end else begin
            hiwater_d = hiwater_q;
        end
    end

    // High-water register
    always_ff @(posedge clk) begin
        if (reset) begin
            hiwater_q <= '0;
        end else begin
            hiwater_q <= hiwater_d;
        end
    end

    assign frame_hiwater = hiwater_q;
`else
    assign frame_hiwater = '0;
`endif

    assign cmd_ready   = (state_q == S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_data    = rsp_data_q;
    assign stk_op      = stk_op_q;
    assign stk_data    = stk_data_q;
    assign stk_limit   = stk_limit_q;
    assign frame_depth = frame_depth_q;

endmodule
